// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and its neighbours.
// Holds the default data width, the NOP encoding, the opcode constants,
// the next-PC mux encodings driven by uc_asm and the fetch FSM states.
package riscv_pkg;

    // Default data/address width of the core
    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0 -- what IR holds until the first real fetch completes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes that uc_asm decodes from instr[6:0]
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // pc_next_sel encodings: sequential/branch adder or JALR ALU target
    localparam logic PC_NEXT_ADDER = 1'b0;
    localparam logic PC_NEXT_ALU   = 1'b1;

    // pc_adder_sel encodings: second adder operand
    localparam logic PC_ADD_4   = 1'b0;
    localparam logic PC_ADD_IMM = 1'b1;

    // Fetch handshake FSM: idle, or waiting for imem_ack
    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    // True when an address is not on a 4-byte instruction boundary
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_logic.sv
// Combinational next-PC computation for the fetch stage.
// Produces the sequential link value pc+4 and the next-PC candidate chosen by
// pc_adder_sel (pc+4 or pc+imm) and pc_next_sel (adder or JALR ALU target
// with bit 0 forced low). All sums wrap modulo 2^XLEN.
module pc_next_logic
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            pc_next_sel,
    input  logic            pc_adder_sel,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next
);

    logic [XLEN-1:0] adder_operand;
    logic [XLEN-1:0] adder_sum;
    logic [XLEN-1:0] jalr_target;

    // Select the adder operand, form the sums and pick the final target
    always_comb begin
        adder_operand = XLEN'(4);
        pc_plus4      = pc + XLEN'(4);
        if (pc_adder_sel == PC_ADD_IMM) begin
            adder_operand = imm;
        end
        adder_sum   = pc + adder_operand;
        jalr_target = alu_result & ~XLEN'(1);
        pc_next     = adder_sum;
        if (pc_next_sel == PC_NEXT_ALU) begin
            pc_next = jalr_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR and runs the req/ack handshake
// towards instruction memory on behalf of the multicycle control unit.
// A fetch latches the current PC into imem_addr and holds it until the ack,
// so PC updates during a fetch never disturb the in-flight address.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds a sticky 'misaligned'
// output: misaligned next-PC writes are dropped and further fetches blocked.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_pc,
    input  logic            load_ir,
    input  logic            pc_next_sel,
    input  logic            pc_adder_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic            fetch_busy,
    output logic            ir_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_next;
    logic            pc_write_ok;
    logic            fetch_ok;

    pc_next_logic #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc           (pc),
        .imm          (imm),
        .alu_result   (alu_result),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .pc_plus4     (pc_plus4),
        .pc_next      (pc_next)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    assign pc_write_ok = !is_misaligned(pc_next[1:0]);
    assign fetch_ok    = !misaligned;

    // Sticky trap flag: set by a misaligned PC write attempt, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else if (load_pc && !pc_write_ok) begin
            misaligned <= 1'b1;
        end
    end
`else
    assign pc_write_ok = 1'b1;
    assign fetch_ok    = 1'b1;
`endif

    assign opcode     = instr[6:0];
    assign fetch_busy = (state == FETCH_WAIT);

    // PC register: takes the next-PC whenever uc_asm asks, in any fetch state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load_pc && pc_write_ok) begin
            pc <= pc_next;
        end
    end

    // Fetch FSM with registered request, address, IR and valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            instr     <= XLEN'(NOP_INSTR);
            ir_valid  <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (load_ir && fetch_ok) begin
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                        state    <= FETCH_IDLE;
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset values, single-cycle and delayed
// acks, next-PC arithmetic including wrap-around, PC updates mid-fetch,
// reset mid-fetch and the optional FETCH_MISALIGN_TRAP_EN behaviour.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        load_pc;
    logic        load_ir;
    logic        pc_next_sel;
    logic        pc_adder_sel;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        fetch_busy;
    logic        ir_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_pc      (load_pc),
        .load_ir      (load_ir),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .imm          (imm),
        .alu_result   (alu_result),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .opcode       (opcode),
        .fetch_busy   (fetch_busy),
        .ir_valid     (ir_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of address, so a wrong address shows up
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0013;
    endfunction

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic lpc, input logic lir,
                                  input logic nsel, input logic asel,
                                  input logic [31:0] imm_v, input logic [31:0] alu_v);
        load_pc      = lpc;
        load_ir      = lir;
        pc_next_sel  = nsel;
        pc_adder_sel = asel;
        imm          = imm_v;
        alu_result   = alu_v;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s wrong", tag);
        end
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_instr", instr, 32'h0000_0013);
        check_output("rst_req", {31'b0, imem_req}, 32'h0);
        check_output("rst_addr", imem_addr, 32'h0);
        check_output("rst_busy", {31'b0, fetch_busy}, 32'h0);
        check_output("rst_valid", {31'b0, ir_valid}, 32'h0);
        check_output("rst_opcode", {25'b0, opcode}, 32'h13);
        check_output("rst_plus4", pc_plus4, 32'h4);

        // Stale ack while idle has no effect
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check_output("stale_instr", instr, 32'h0000_0013);
        check_output("stale_valid", {31'b0, ir_valid}, 32'h0);

        // Single fetch with ack in the first request cycle
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        load_ir = 1'b0;
        check_output("f1_req", {31'b0, imem_req}, 32'h1);
        check_output("f1_addr", imem_addr, 32'h0);
        check_output("f1_busy", {31'b0, fetch_busy}, 32'h1);
        check_output("f1_valid_early", {31'b0, ir_valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0010_0093;
        tick();
        imem_ack = 1'b0;
        check_output("f1_instr", instr, 32'h0010_0093);
        check_output("f1_opcode", {25'b0, opcode}, 32'h13);
        check_output("f1_valid", {31'b0, ir_valid}, 32'h1);
        check_output("f1_req_drop", {31'b0, imem_req}, 32'h0);
        check_output("f1_busy_drop", {31'b0, fetch_busy}, 32'h0);
        tick();
        check_output("f1_valid_pulse", {31'b0, ir_valid}, 32'h0);

        // Step PC to 4, then fetch with a 3-cycle delayed ack
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        load_pc = 1'b0;
        check_output("seq_pc", pc, 32'h4);
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        check_output("d_req_c1", {31'b0, imem_req}, 32'h1);
        check_output("d_addr_c1", imem_addr, 32'h4);
        check_output("d_busy_c1", {31'b0, fetch_busy}, 32'h1);
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        check_output("d_req_c2", {31'b0, imem_req}, 32'h1);
        check_output("d_addr_c2", imem_addr, 32'h4);
        check_output("d_busy_c2", {31'b0, fetch_busy}, 32'h1);
        tick();
        check_output("d_req_c3", {31'b0, imem_req}, 32'h1);
        check_output("d_addr_c3", imem_addr, 32'h4);
        check_output("d_valid_c3", {31'b0, ir_valid}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack = 1'b0;
        check_output("d_instr", instr, 32'hA5A5_0017);
        check_output("d_valid", {31'b0, ir_valid}, 32'h1);
        check_output("d_req_drop", {31'b0, imem_req}, 32'h0);
        tick();
        check_output("d_no_queue_req", {31'b0, imem_req}, 32'h0);
        check_output("d_no_queue_busy", {31'b0, fetch_busy}, 32'h0);

        // Next-PC arithmetic: pc 4 -> 0x10 -> 0x08 -> JALR 0x104
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h0);
        tick();
        check_output("imm_pc_10", pc, 32'h10);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
        tick();
        check_output("imm_neg_pc", pc, 32'h08);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0105);
        tick();
        load_pc = 1'b0;
        check_output("jalr_pc", pc, 32'h104);
        check_output("jalr_plus4", pc_plus4, 32'h108);

        // PC update during WAIT leaves the in-flight address alone
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        load_pc = 1'b0;
        check_output("wpc_pc", pc, 32'h108);
        check_output("wpc_addr", imem_addr, 32'h104);
        check_output("wpc_req", {31'b0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack = 1'b0;
        check_output("wpc_instr", instr, 32'hA5A5_0117);

        // load_pc and load_ir together in IDLE: fetch uses the old pc
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("both_addr", imem_addr, 32'h108);
        check_output("both_pc", pc, 32'h10C);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        imem_ack = 1'b0;
        check_output("both_instr", instr, 32'hA5A5_011B);

        // Reset in the middle of a fetch, ack arriving just after
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        check_output("rmid_req_pre", {31'b0, imem_req}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("rmid_req", {31'b0, imem_req}, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        check_output("rmid_instr", instr, 32'h0000_0013);
        check_output("rmid_valid", {31'b0, ir_valid}, 32'h0);
        check_output("rmid_pc", pc, 32'h0);
        check_output("rmid_busy", {31'b0, fetch_busy}, 32'h0);

        // Wrap-around: JALR to 0xFFFF_FFFC then +4 wraps to 0
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFD);
        tick();
        check_output("wrap_hi_pc", pc, 32'hFFFF_FFFC);
        check_output("wrap_plus4", pc_plus4, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        load_pc = 1'b0;
        check_output("wrap_pc", pc, 32'h0);

        // Misaligned JALR target 0x102
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0103);
        tick();
        load_pc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check_output("mis_pc_kept", pc, 32'h0);
        check_output("mis_flag", {31'b0, misaligned}, 32'h1);
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
        check_output("mis_no_req", {31'b0, imem_req}, 32'h0);
        check_output("mis_sticky", {31'b0, misaligned}, 32'h1);
`else
        check_output("mis_pc_written", pc, 32'h102);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
